store_buffer: RTL and testbench

//  Posted-write queue between the MEM pipeline stage and data_memory. Stores are

---
 rtl/store_buffer.sv | 118 +++++++++++
 tb/tb_store_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write queue ahead of data_memory: stores accepted in one cycle, drained when the port is free.
// Loads win the port and forward from the youngest queued match; st_ready drops only when full with no drain.
module store_buffer #(
   parameter int ISIZE        = 16,
   parameter int DSIZE        = 16,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st_valid,
   input  logic [ISIZE-1:0] st_addr,
   input  logic [DSIZE-1:0] st_data,
   output logic             st_ready,
   input  logic             ld_valid,
   input  logic [ISIZE-1:0] ld_addr,
   output logic [DSIZE-1:0] ld_data,
   output logic             ld_stall,
   input  logic             flush,
   output logic             empty,
   output logic             dm_wen,
   output logic             dm_ren,
   output logic [ISIZE-1:0] dm_addr,
   output logic [DSIZE-1:0] dm_write_data,
   input  logic [DSIZE-1:0] dm_read_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [ISIZE-1:0] addr;
      logic [DSIZE-1:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q;
   logic [SW-1:0]   starve_q;

   logic            force_drain;
   logic            not_empty;
   logic            full;
   logic            drain;
   logic            load;
   logic            push;
   logic            fwd_hit;
   logic [DSIZE-1:0] fwd_data;
   logic [PW-1:0]   idx;

   assign not_empty   = (count_q != '0);
   assign full        = (count_q == CW'(DEPTH));
   assign force_drain = flush | (starve_q == SW'(STARVE_LIMIT));
   assign drain       = not_empty & (~ld_valid | force_drain);
   assign load        = ld_valid & ~drain;
   assign st_ready    = ~full | drain;
   assign push        = st_valid & st_ready;
   assign ld_stall    = ld_valid & drain;
   assign empty       = ~not_empty;

   // Walk oldest to youngest so the last match left standing is the youngest store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && (mem_q[idx].addr == ld_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_q[idx].data;
         end
      end
   end

   always_comb begin
      dm_wen        = 1'b0;
      dm_ren        = 1'b0;
      dm_addr       = '0;
      dm_write_data = '0;
      ld_data       = '0;
      if (drain) begin
         dm_wen        = 1'b1;
         dm_addr       = mem_q[head_q].addr;
         dm_write_data = mem_q[head_q].data;
      end else if (load) begin
         dm_ren  = 1'b1;
         dm_addr = ld_addr;
         ld_data = fwd_hit ? fwd_data : dm_read_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_q[tail_q] <= '{addr: st_addr, data: st_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (drain) head_q <= head_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(drain);
         // Loads starving a full queue eventually force one entry out.
         if (drain || !full) begin
            starve_q <= '0;
         end else if (ld_valid && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_q <= starve_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small memory model behind the dm_* port.
module tb_store_buffer;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic [15:0] st_addr;
   logic [15:0] st_data;
   logic        st_ready;
   logic        ld_valid;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;
   logic        ld_stall;
   logic        flush;
   logic        empty;
   logic        dm_wen;
   logic        dm_ren;
   logic [15:0] dm_addr;
   logic [15:0] dm_write_data;
   logic [15:0] dm_read_data;

   logic [15:0] tbmem [256];
   logic [31:0] wr_log [$];
   int          errors;
   int          checks;

   store_buffer #(.ISIZE(16), .DSIZE(16), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
      .flush(flush), .empty(empty),
      .dm_wen(dm_wen), .dm_ren(dm_ren), .dm_addr(dm_addr),
      .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_read_data = tbmem[dm_addr[7:0]];

   always @(posedge clk) begin
      if (rst && dm_wen === 1'b1) begin
         tbmem[dm_addr[7:0]] <= dm_write_data;
         wr_log.push_back({dm_addr, dm_write_data});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; st_valid = 1'b1; st_addr = 16'h0099; st_data = 16'h1234;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (dm_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", dm_wen); end
      end
      st_valid = 1'b0; rst = 1'b1;
      #1;
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
      checks++;
      if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready: got %b want 1", st_ready); end
      checks++;
      if ({dm_wen, dm_ren, ld_stall} !== 3'b000) begin errors++; $display("FAIL rst_ctl: got %b want 000", {dm_wen, dm_ren, ld_stall}); end
      checks++;
      if ({ld_data, dm_addr, dm_write_data} !== 48'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {ld_data, dm_addr, dm_write_data}); end
      tick();
      checks++;
      if (wr_log.size() != 0) begin errors++; $display("FAIL rst_no_write: got %0d writes want 0", wr_log.size()); end
   endtask

   task automatic test_forward();
      st_valid = 1'b1; st_addr = 16'h0010; st_data = 16'hBEEF; ld_valid = 1'b0;
      #1;
      checks++;
      if (st_ready !== 1'b1) begin errors++; $display("FAIL fwd_st_ready: got %b want 1", st_ready); end
      tick();
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 16'h0010;
      #1;
      checks++;
      if (ld_data !== 16'hBEEF) begin errors++; $display("FAIL fwd_data: got %h want beef", ld_data); end
      checks++;
      if ({dm_wen, dm_ren, ld_stall} !== 3'b010) begin errors++; $display("FAIL fwd_ctl: got %b want 010", {dm_wen, dm_ren, ld_stall}); end
      tick();
      ld_valid = 1'b0;
      #1;
      checks++;
      if ({dm_wen, dm_addr, dm_write_data} !== {1'b1, 16'h0010, 16'hBEEF}) begin
         errors++; $display("FAIL fwd_drain: got %b %h %h want 1 0010 beef", dm_wen, dm_addr, dm_write_data);
      end
      tick();
      checks++;
      if (empty !== 1'b1 || tbmem[8'h10] !== 16'hBEEF) begin
         errors++; $display("FAIL fwd_mem: got empty=%b mem=%h want 1 beef", empty, tbmem[8'h10]);
      end
   endtask

   task automatic test_order();
      int n;
      ld_valid = 1'b1; ld_addr = 16'h0020;
      st_valid = 1'b1; st_addr = 16'h0020; st_data = 16'h0001;
      #1;
      checks++;
      if (ld_data !== 16'hC020) begin errors++; $display("FAIL same_cycle_nofwd: got %h want c020", ld_data); end
      tick();
      st_data = 16'h0002;
      #1;
      checks++;
      if (ld_data !== 16'h0001) begin errors++; $display("FAIL order_fwd1: got %h want 0001", ld_data); end
      tick();
      st_valid = 1'b0;
      #1;
      checks++;
      if (ld_data !== 16'h0002) begin errors++; $display("FAIL order_youngest: got %h want 0002", ld_data); end
      tick();
      ld_valid = 1'b0;
      n = wr_log.size();
      tick();
      tick();
      checks++;
      if (wr_log.size() != n + 2) begin
         errors++; $display("FAIL order_count: got %0d writes want %0d", wr_log.size() - n, 2);
      end else if (wr_log[n] !== 32'h0020_0001 || wr_log[n+1] !== 32'h0020_0002) begin
         errors++; $display("FAIL order_seq: got %h %h want 00200001 00200002", wr_log[n], wr_log[n+1]);
      end
   endtask

   task automatic test_starve();
      ld_valid = 1'b1; ld_addr = 16'h0040;
      for (int i = 0; i < 4; i++) begin
         st_valid = 1'b1; st_addr = 16'h0050 + 16'(i); st_data = 16'h1000 + 16'(i);
         tick();
      end
      st_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++;
         if (st_ready !== 1'b0 || ld_stall !== 1'b0) begin
            errors++; $display("FAIL starve_hold%0d: got rdy=%b stall=%b want 0 0", c, st_ready, ld_stall);
         end
         tick();
      end
      #1;
      checks++;
      if ({ld_stall, dm_wen, dm_addr, dm_write_data, ld_data} !== {2'b11, 16'h0050, 16'h1000, 16'h0000}) begin
         errors++; $display("FAIL starve_force: got stall=%b wen=%b %h %h ld=%h want 1 1 0050 1000 0000",
                            ld_stall, dm_wen, dm_addr, dm_write_data, ld_data);
      end
      tick();
      st_valid = 1'b1; st_addr = 16'h0054; st_data = 16'h1004;
      #1;
      checks++;
      if ({st_ready, ld_stall, dm_ren, ld_data} !== {3'b101, 16'hC040}) begin
         errors++; $display("FAIL starve_resume: got rdy=%b stall=%b ren=%b ld=%h want 1 0 1 c040",
                            st_ready, ld_stall, dm_ren, ld_data);
      end
      tick();
      st_valid = 1'b0;
   endtask

   task automatic test_wrap();
      int n;
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         st_valid = 1'b1; st_addr = 16'h0060 + 16'(k); st_data = 16'h2000 + 16'(k);
         #1;
         checks++;
         if ({st_ready, dm_wen, dm_addr} !== {2'b11, 16'h0051 + 16'(k)}) begin
            errors++; $display("FAIL wrap_pushpop%0d: got rdy=%b wen=%b addr=%h want 1 1 %h",
                               k, st_ready, dm_wen, dm_addr, 16'h0051 + 16'(k));
         end
         tick();
      end
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 16'h0062;
      #1;
      checks++;
      if ({st_ready, ld_stall, ld_data} !== {2'b00, 16'h2002}) begin
         errors++; $display("FAIL wrap_full_fwd: got rdy=%b stall=%b ld=%h want 0 0 2002", st_ready, ld_stall, ld_data);
      end
      tick();
      ld_valid = 1'b0;
      n = wr_log.size();
      repeat (4) tick();
      checks++;
      if (wr_log.size() != n + 4 || empty !== 1'b1) begin
         errors++; $display("FAIL wrap_drain_count: got %0d writes empty=%b want 4 1", wr_log.size() - n, empty);
      end else if (wr_log[n] !== 32'h0060_2000 || wr_log[n+1] !== 32'h0061_2001 ||
                   wr_log[n+2] !== 32'h0062_2002 || wr_log[n+3] !== 32'h0063_2003) begin
         errors++; $display("FAIL wrap_drain_seq: got %h %h %h %h want 00602000..00632003",
                            wr_log[n], wr_log[n+1], wr_log[n+2], wr_log[n+3]);
      end
   endtask

   task automatic test_flush();
      ld_valid = 1'b1; ld_addr = 16'h0070;
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1; st_addr = 16'h0071 + 16'(i); st_data = 16'h3001 + 16'(i);
         tick();
      end
      st_valid = 1'b0; flush = 1'b1; ld_addr = 16'h0071;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({ld_stall, dm_wen, dm_ren, dm_addr, dm_write_data, ld_data} !==
             {3'b110, 16'h0071 + 16'(k), 16'h3001 + 16'(k), 16'h0000}) begin
            errors++; $display("FAIL flush_drain%0d: got stall=%b wen=%b ren=%b %h %h ld=%h",
                               k, ld_stall, dm_wen, dm_ren, dm_addr, dm_write_data, ld_data);
         end
         tick();
      end
      #1;
      checks++;
      if ({empty, ld_stall, dm_ren, ld_data} !== {3'b101, 16'h3001}) begin
         errors++; $display("FAIL flush_empty_load: got empty=%b stall=%b ren=%b ld=%h want 1 0 1 3001",
                            empty, ld_stall, dm_ren, ld_data);
      end
      tick();
      flush = 1'b0; ld_valid = 1'b0;
   endtask

   initial begin
      errors = 0; checks = 0;
      for (int a = 0; a < 256; a++) tbmem[a] = 16'hC000 | 16'(a);
      rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
      ld_valid = 1'b0; ld_addr = '0; flush = 1'b0;
      test_reset();
      test_forward();
      test_order();
      test_starve();
      test_wrap();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
